// File: rtl/ram_wr_arbiter.sv
// ram_wr_arbiter: round-robin write-port controller for the register-file RAM,
// with a zero-fill sweep of every address after reset or on clear.
module ram_wr_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             clear_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic                             busy_o,
    output logic                             clear_done_o,
    output logic                             we_o,
    output logic [ADDR_WIDTH-1:0]            w_addr_o,
    output logic [DATA_WIDTH-1:0]            w_data_o
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [0:0] SWEEP = 1'b0, ARB = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    localparam logic [PW-1:0] PMAX = PW'(NUM_REQ - 1);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  we_q, we_d, done_q, done_d;
    logic [PW:0]           sel;
    logic                  sweep, acc;

    // Returns {found, index} of the first valid requester at or after p, wrapping explicitly.
    function automatic logic [PW:0] pick(input logic [NUM_REQ-1:0] v, input logic [PW-1:0] p);
        logic [PW-1:0] j;
        j = p;
        pick = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick[PW] && v[j]) pick = {1'b1, j};
            j = (j == PMAX) ? '0 : j + 1'b1;
        end
    endfunction

    assign sel   = pick(req_valid_i, ptr_q);
    assign sweep = (state_q == SWEEP);
    assign acc   = !sweep && sel[PW];

    always_comb begin
        state_d = sweep ? ((cnt_q == LAST) ? ARB : SWEEP) : (clear_i ? SWEEP : ARB);
        cnt_d   = sweep ? cnt_q + 1'b1 : '0;
        ptr_d   = acc ? ((sel[PW-1:0] == PMAX) ? '0 : sel[PW-1:0] + 1'b1) : ptr_q;
        we_d    = sweep || acc;
        addr_d  = sweep ? cnt_q : acc ? req_addr_i[sel[PW-1:0]*ADDR_WIDTH +: ADDR_WIDTH] : addr_q;
        data_d  = sweep ? '0 : acc ? req_data_i[sel[PW-1:0]*DATA_WIDTH +: DATA_WIDTH] : data_q;
        done_d  = sweep && (cnt_q == LAST);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign req_ready_o  = acc ? NUM_REQ'(1) << sel[PW-1:0] : '0;
    assign busy_o       = sweep;
    assign clear_done_o = done_q;
    assign we_o         = we_q;
    assign w_addr_o     = addr_q;
    assign w_data_o     = data_q;
endmodule

// File: tb/tb_ram_wr_arbiter.sv
// tb_ram_wr_arbiter: directed checks of sweep, round-robin grants, clear and reset,
// with a behavioural RAM capturing the write port.
`timescale 1ns/1ps
module tb_ram_wr_arbiter;
    logic        clk = 1'b0, reset, clear;
    logic [3:0]  valid, ready;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        busy, done, we;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  mem [8];
    int          npass = 0, ntotal = 0;

    ram_wr_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_REQ(4)) dut (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .req_valid_i(valid),
        .req_addr_i(raddr), .req_data_i(rdata), .req_ready_o(ready), .busy_o(busy),
        .clear_done_o(done), .we_o(we), .w_addr_o(waddr), .w_data_o(wdata)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        raddr[i*3 +: 3] = a;
        rdata[i*8 +: 8] = d;
    endtask

    task automatic sweep_check;
        for (int c = 0; c < 8; c++) begin
            step;
            chk("sweep_we", we, 1);
            chk("sweep_addr", waddr, c);
            chk("sweep_data", wdata, 0);
            chk("sweep_done", done, c == 7);
            chk("sweep_ready", ready, 0);
            chk("sweep_busy", busy, c != 7);
            if (c == 6) valid = 4'b0000;
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; valid = '0; raddr = '0; rdata = '0;
        step; step;
        chk("rst_we", we, 0);
        chk("rst_addr", waddr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 1);
        reset = 1'b0;
        sweep_check;
        step;
        chk("idle_we", we, 0);
        chk("idle_ready", ready, 0);

        // single request from requester 2; pointer then 3
        set_req(2, 3'd5, 8'hA5); valid = 4'b0100; #1;
        chk("r2_ready", ready, 4'b0100);
        step; valid = '0; #1;
        chk("r2_ready_after", ready, 0);
        chk("r2_we", we, 1);
        chk("r2_addr", waddr, 5);
        chk("r2_data", wdata, 8'hA5);
        step;
        chk("r2_we_off", we, 0);
        chk("r2_mem", mem[5], 8'hA5);

        // pointer at 3 with 1 and 3 valid
        set_req(1, 3'd1, 8'h11); set_req(3, 3'd6, 8'h36); valid = 4'b1010; #1;
        chk("p3_first", ready, 4'b1000);
        step; valid[3] = 1'b0; #1;
        chk("p3_second", ready, 4'b0010);
        chk("p3_w1_addr", waddr, 6);
        chk("p3_w1_data", wdata, 8'h36);
        step; valid = '0; #1;
        chk("p3_w2_addr", waddr, 1);
        chk("p3_w2_data", wdata, 8'h11);
        chk("p3_ready_off", ready, 0);
        set_req(0, 3'd3, 8'h03); valid = 4'b0001; #1;
        chk("p2_sole0", ready, 4'b0001);
        step; valid = '0;
        set_req(3, 3'd4, 8'h44); valid = 4'b1000; #1;
        chk("p1_sole3", ready, 4'b1000);
        chk("p1_w_addr", waddr, 3);
        step; valid = '0; #1;
        chk("p0_w_data", wdata, 8'h44);

        // all four valid from pointer 0
        for (int i = 0; i < 4; i++) set_req(i, 3'(7 - i), 8'(8'hC0 + i));
        valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready", ready, 4'b0001 << i);
            if (i > 0) begin
                chk("rr_we", we, 1);
                chk("rr_addr", waddr, 7 - (i - 1));
            end
            step; valid[i] = 1'b0;
        end
        #1;
        chk("rr_last_addr", waddr, 4);
        chk("rr_last_data", wdata, 8'hC3);
        chk("rr_ready_off", ready, 0);

        // same address, consecutive grants: last one wins
        set_req(1, 3'd5, 8'h55); set_req(2, 3'd5, 8'h66); valid = 4'b0110;
        step; valid[1] = 1'b0;
        step; valid = '0;
        step;
        chk("waw_mem", mem[5], 8'h66);

        // clear together with an accept from requester 0 (pointer 3)
        set_req(0, 3'd2, 8'h11); valid = 4'b0001; clear = 1'b1; #1;
        chk("clr_ready", ready, 4'b0001);
        step; clear = 1'b0; valid = 4'b1111; #1;
        chk("clr_we", we, 1);
        chk("clr_addr", waddr, 2);
        chk("clr_data", wdata, 8'h11);
        chk("clr_busy", busy, 1);
        chk("clr_ready_off", ready, 0);
        sweep_check;
        step;
        chk("clr_mem2", mem[2], 0);

        // reset during the 4th sweep cycle
        clear = 1'b1;
        step; clear = 1'b0;
        step; step; step; step;
        chk("mid_addr3", waddr, 3);
        reset = 1'b1; #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_addr", waddr, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_done", done, 0);
        step; step;
        chk("mid_hold_we", we, 0);
        reset = 1'b0;
        sweep_check;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
